popcount_req_arbiter: RTL and testbench

- Shares one VecPopcount pipeline between NUM_REQ independent requesters (e.g. per-channel Hamming-distance engines).
- Round-robin arbitrates input vectors into the pipeline and records each issued requester ID in an in-order tag FIFO.
- Routes each popcount result back to its originator with per-requester valid/ready handshakes.
- Sits between requester engines and a single VecPopcount instance; adds zero latency.

---
 rtl/popcount_req_arbiter.sv | 131 +++++++++++++
 tb/tb_popcount_req_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_req_arbiter.sv
// Round-robin front end that shares one VecPopcount pipeline among NUM_REQ requesters.
// Issued requester IDs ride an in-order tag FIFO so each result is steered back to its originator.
module popcount_req_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int VEC_WIDTH       = 1100,
    parameter int POPCNT_WIDTH    = $clog2(VEC_WIDTH + 1),
    parameter int MAX_OUTSTANDING = 16,
    parameter int ID_WIDTH        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*VEC_WIDTH-1:0]           req_vec,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    input  logic [NUM_REQ-1:0]                     rsp_ready,
    output logic [POPCNT_WIDTH-1:0]                rsp_popcount,
    output logic [ID_WIDTH-1:0]                    rsp_id,
    output logic [VEC_WIDTH-1:0]                   pc_vec,
    output logic                                   pc_in_valid,
    input  logic                                   pc_this_ready,
    input  logic                                   pc_out_valid,
    output logic                                   pc_next_ready,
    input  logic [POPCNT_WIDTH-1:0]                pc_popcount,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   err
);

    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_WIDTH = $clog2(MAX_OUTSTANDING);

    logic [ID_WIDTH-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [PTR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_WIDTH-1:0] count_reg, count_next;
    logic                 err_reg, err_next;
    logic [ID_WIDTH-1:0]  tag_mem [MAX_OUTSTANDING];

    logic [VEC_WIDTH-1:0] vec_slice [NUM_REQ];
    logic [ID_WIDTH-1:0]  winner;
    logic [ID_WIDTH-1:0]  scan_id;
    logic                 has_winner;
    logic [ID_WIDTH-1:0]  head;
    logic                 empty, full, fire, pop, rsp_active;

    // Scan from rr_ptr upward; the descending loop lets the nearest valid requester win.
    always_comb begin
        winner     = '0;
        has_winner = 1'b0;
        scan_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_id = ID_WIDTH'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (req_valid[scan_id]) begin
                winner     = scan_id;
                has_winner = 1'b1;
            end
        end
    end

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_WIDTH'(MAX_OUTSTANDING));
    assign head  = tag_mem[rd_ptr_reg];

    assign pc_in_valid   = !rst && (|req_valid) && !full;
    assign fire          = pc_in_valid && pc_this_ready;
    assign pc_vec        = has_winner ? vec_slice[winner] : '0;
    assign pc_next_ready = !rst && !empty && rsp_ready[head];
    assign pop           = pc_out_valid && pc_next_ready;
    assign rsp_active    = !rst && pc_out_valid && !empty;
    assign rsp_popcount  = pc_popcount;
    assign rsp_id        = head;
    assign outstanding   = count_reg;
    assign err           = err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign vec_slice[gi] = req_vec[gi*VEC_WIDTH +: VEC_WIDTH];
            assign req_ready[gi] = fire && (winner == ID_WIDTH'(gi));
            assign rsp_valid[gi] = rsp_active && (head == ID_WIDTH'(gi));
        end
    endgenerate

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        err_next    = err_reg | (pc_out_valid && empty);
        if (fire) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
            if (winner == ID_WIDTH'(NUM_REQ - 1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = winner + 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        // A simultaneous push and pop leave the occupancy unchanged.
        if (fire && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!fire && pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            err_reg    <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            tag_mem[wr_ptr_reg] <= winner;
        end
    end

endmodule

// File: tb/tb_popcount_req_arbiter.sv
// Bench for popcount_req_arbiter: a fixed-latency VecPopcount model plus a scoreboard of issued tags.
module tb_popcount_req_arbiter;

    localparam int N    = 4;
    localparam int VW   = 1100;
    localparam int PW   = 11;
    localparam int MO   = 16;
    localparam int IDW  = 2;
    localparam int CW   = 5;
    localparam int LAT  = 3;
    localparam int MCAP = 24;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*VW-1:0] req_vec = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [PW-1:0]   rsp_popcount;
    logic [IDW-1:0]  rsp_id;
    logic [VW-1:0]   pc_vec;
    logic            pc_in_valid;
    logic            pc_this_ready;
    logic            pc_out_valid;
    logic            pc_next_ready;
    logic [PW-1:0]   pc_popcount;
    logic [CW-1:0]   outstanding;
    logic            err;

    popcount_req_arbiter #(
        .NUM_REQ(N), .VEC_WIDTH(VW), .POPCNT_WIDTH(PW), .MAX_OUTSTANDING(MO), .ID_WIDTH(IDW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_vec(req_vec),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_popcount(rsp_popcount), .rsp_id(rsp_id),
        .pc_vec(pc_vec), .pc_in_valid(pc_in_valid), .pc_this_ready(pc_this_ready),
        .pc_out_valid(pc_out_valid), .pc_next_ready(pc_next_ready), .pc_popcount(pc_popcount),
        .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    // VecPopcount stand-in: fixed latency, deep enough to hold MAX_OUTSTANDING results.
    typedef struct { logic [PW-1:0] pc; int t; } mitem_t;
    mitem_t        mq[$];
    int            cyc = 0;
    logic          mo_valid = 1'b0;
    logic          mo_ready = 1'b1;
    logic [PW-1:0] mo_pc = '0;
    logic          force_ov = 1'b0;

    assign pc_out_valid  = mo_valid | force_ov;
    assign pc_this_ready = mo_ready;
    assign pc_popcount   = mo_pc;

    initial begin
        mitem_t it;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
            end else begin
                if (mo_valid && pc_next_ready) void'(mq.pop_front());
                if (pc_in_valid && mo_ready) begin
                    it.pc = PW'($countones(pc_vec));
                    it.t  = cyc + LAT;
                    mq.push_back(it);
                end
            end
            cyc = cyc + 1;
            if (mq.size() > 0) begin
                mo_valid <= (cyc >= mq[0].t);
                mo_pc    <= mq[0].pc;
            end else begin
                mo_valid <= 1'b0;
                mo_pc    <= '0;
            end
            mo_ready <= (mq.size() < MCAP);
        end
    end

    typedef struct { logic [IDW-1:0] id; logic [PW-1:0] pc; } exp_t;
    exp_t          sb[$];
    int            issue_log[$];
    int            issue_step[$];
    int            rsp_log[$];
    int            credits[N];
    logic [VW-1:0] vecs[N];
    logic          cfg_rst = 1'b1;
    logic [N-1:0]  cfg_rsp_ready = '1;
    logic          cfg_force = 1'b0;
    int            cnt_m = 0;
    int            rr_m = 0;
    logic          err_m = 1'b0;
    int            stepn = 0;
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] make_vec(input int n, input int off);
        logic [VW-1:0] v = '0;
        for (int b = 0; b < n; b++) v[b*5+off] = 1'b1;
        return v;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += credits[i];
        return s;
    endfunction

    // One cycle: drive at negedge, compare against the reference model, then advance the model.
    task automatic step();
        int            win;
        logic          have, in_v, fire, nonempty, nr, pop;
        logic [N-1:0]  exp_rv;
        logic [IDW-1:0] hid;
        exp_t          e;
        @(negedge clk);
        rst       = cfg_rst;
        rsp_ready = cfg_rsp_ready;
        force_ov  = cfg_force;
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = (credits[i] > 0);
            req_vec[i*VW +: VW]  = vecs[i];
        end
        #1;
        stepn++;
        have = 1'b0;
        win  = 0;
        for (int k = 0; k < N; k++) begin
            if (!have && req_valid[(rr_m + k) % N]) begin
                have = 1'b1;
                win  = (rr_m + k) % N;
            end
        end
        in_v = !rst && have && (cnt_m < MO);
        fire = in_v && pc_this_ready;
        check("req_ready", 32'(req_ready), fire ? 32'(1) << win : 32'(0));
        check("pc_in_valid", 32'(pc_in_valid), 32'(in_v));
        if (in_v) check("pc_vec", 32'(pc_vec === vecs[win]), 32'(1));
        check("outstanding", 32'(outstanding), 32'(cnt_m));
        check("err", 32'(err), 32'(err_m));
        nonempty = (sb.size() > 0);
        hid = nonempty ? sb[0].id : '0;
        nr  = !rst && nonempty && rsp_ready[hid];
        check("pc_next_ready", 32'(pc_next_ready), 32'(nr));
        exp_rv = (!rst && pc_out_valid && nonempty) ? (N'(1) << hid) : '0;
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv != '0) begin
            check("rsp_id", 32'(rsp_id), 32'(hid));
            check("rsp_popcount", 32'(rsp_popcount), 32'(sb[0].pc));
        end
        pop = pc_out_valid && nr;
        if (rst) begin
            sb.delete();
            cnt_m = 0;
            rr_m  = 0;
            err_m = 1'b0;
        end else begin
            if (pc_out_valid && !nonempty) err_m = 1'b1;
            if (pop) begin
                rsp_log.push_back(int'(sb[0].pc));
                void'(sb.pop_front());
            end
            if (fire) begin
                e.id = IDW'(win);
                e.pc = PW'($countones(vecs[win]));
                sb.push_back(e);
                credits[win]--;
                rr_m = (win + 1) % N;
                issue_log.push_back(win);
                issue_step.push_back(stepn);
            end
            cnt_m = cnt_m + int'(fire) - int'(pop);
        end
    endtask

    task automatic run_until_idle(input string tag);
        int g = 0;
        while ((pending() > 0 || sb.size() > 0) && g < 300) begin
            step();
            g++;
        end
        check(tag, 32'(g < 300), 32'(1));
    endtask

    task automatic clear_logs();
        issue_log.delete();
        issue_step.delete();
        rsp_log.delete();
    endtask

    initial begin
        int lat;
        int g;
        for (int i = 0; i < N; i++) begin
            credits[i] = 0;
            vecs[i]    = make_vec(10 * (i + 1), i);
        end

        // Reset and idle state
        cfg_rst = 1'b1;
        step();
        step();
        cfg_rst = 1'b0;
        step();
        check("reset_outstanding", 32'(outstanding), 32'(0));
        check("reset_err", 32'(err), 32'(0));
        check("reset_rsp_valid", 32'(rsp_valid), 32'(0));

        // Single all-ones request from requester 2
        vecs[2]    = '1;
        credits[2] = 1;
        step();
        check("t1_grant", 32'(req_ready), 32'(4'b0100));
        step();
        lat = 1;
        check("t1_outstanding_1", 32'(outstanding), 32'(1));
        while (rsp_valid == '0 && lat < 20) begin
            step();
            lat++;
        end
        check("t1_latency", 32'(lat), 32'(LAT));
        check("t1_rsp_valid", 32'(rsp_valid), 32'(4'b0100));
        check("t1_rsp_popcount", 32'(rsp_popcount), 32'(1100));
        check("t1_rsp_id", 32'(rsp_id), 32'(2));
        step();
        check("t1_outstanding_0", 32'(outstanding), 32'(0));
        check("t1_err", 32'(err), 32'(0));
        vecs[2] = make_vec(30, 2);

        // Fair rotation with all requesters active
        cfg_rst = 1'b1;
        step();
        cfg_rst = 1'b0;
        clear_logs();
        for (int i = 0; i < N; i++) credits[i] = 8;
        run_until_idle("t2_drain");
        check("t2_issue_count", 32'(issue_log.size()), 32'(32));
        check("t2_rsp_count", 32'(rsp_log.size()), 32'(32));
        for (int i = 0; i < 8; i++) begin
            check("t2_issue_order", 32'(issue_log[i]), 32'(i % 4));
            check("t2_rsp_value", 32'(rsp_log[i]), 32'(10 * (i % 4 + 1)));
        end
        for (int i = 0; i < 7; i++) check("t2_back_to_back", 32'(issue_step[i+1] - issue_step[i]), 32'(1));

        // Stalled head saturates the in-flight limit
        clear_logs();
        cfg_rsp_ready = 4'b1101;
        credits[0] = 4; credits[1] = 4; credits[2] = 4; credits[3] = 6;
        for (int i = 0; i < 40; i++) step();
        check("t3_saturated", 32'(outstanding), 32'(16));
        check("t3_req_ready", 32'(req_ready), 32'(0));
        check("t3_next_ready", 32'(pc_next_ready), 32'(0));
        check("t3_req_valid", 32'(req_valid), 32'(4'b1000));

        // Full with a same-cycle pop: issue deferred one cycle
        cfg_rsp_ready = '1;
        step();
        check("t4_pop", 32'(pc_next_ready), 32'(1));
        check("t4_no_issue", 32'(req_ready), 32'(0));
        check("t4_still_full", 32'(outstanding), 32'(16));
        step();
        check("t4_outstanding", 32'(outstanding), 32'(15));
        check("t4_issue", 32'(req_ready), 32'(4'b1000));
        run_until_idle("t3_drain");
        check("t3_rsp_count", 32'(rsp_log.size()), 32'(18));
        for (int i = 0; i < 18; i++)
            check("t3_rsp_order", 32'(rsp_log[i]), (i < 16) ? 32'(10 * (i % 4 + 1)) : 32'(40));

        // Mid-operation reset with 5 outstanding
        cfg_rsp_ready = '0;
        credits[0] = 2; credits[1] = 2; credits[2] = 1;
        g = 0;
        while (pending() > 0 && g < 50) begin
            step();
            g++;
        end
        step();
        check("t5_outstanding_5", 32'(outstanding), 32'(5));
        cfg_rst = 1'b1;
        step();
        cfg_rst = 1'b0;
        credits[0] = 1; credits[2] = 1;
        step();
        check("t5_outstanding_0", 32'(outstanding), 32'(0));
        check("t5_rsp_valid", 32'(rsp_valid), 32'(0));
        check("t5_rr_restart", 32'(req_ready), 32'(4'b0001));
        cfg_rsp_ready = '1;
        run_until_idle("t5_drain");

        // Spurious result with an empty tag FIFO
        cfg_force = 1'b1;
        step();
        check("t6_rsp_valid", 32'(rsp_valid), 32'(0));
        check("t6_no_pop", 32'(pc_next_ready), 32'(0));
        cfg_force = 1'b0;
        step();
        check("t6_err_set", 32'(err), 32'(1));
        for (int i = 0; i < 3; i++) step();
        check("t6_err_sticky", 32'(err), 32'(1));
        cfg_rst = 1'b1;
        step();
        cfg_rst = 1'b0;
        step();
        check("t6_err_cleared", 32'(err), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
